// File: rtl/binary_to_bcd.sv
// Sequential double-dabble converter: binary count -> four registered BCD digits.
// Optional macro BCD_SATURATE_EN clamps out-of-range results to 9999.
module binary_to_bcd #(
  parameter int BIN_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] binary,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [3:0]           thousands,
  output logic [3:0]           hundreds,
  output logic [3:0]           tens,
  output logic [3:0]           ones
);

  localparam int CW = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state;
  state_t               next_state;
  logic [BIN_WIDTH-1:0] shreg;
  logic [19:0]          bcd;
  logic [19:0]          adj;
  logic [CW-1:0]        count;
  logic [BIN_WIDTH+19:0] stepped;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (count == CW'(1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
  end

  // One double-dabble step: correct every nibble that would carry past 9, then shift.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    stepped = {adj, shreg} << 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      bcd   <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= binary;
            bcd   <= '0;
            count <= CW'(BIN_WIDTH);
          end
        end
        SHIFT: begin
          {bcd, shreg} <= stepped;
          count        <= count - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Digits update only when a conversion completes so the display never sees partials.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done      <= 1'b0;
      overflow  <= 1'b0;
      thousands <= 4'd0;
      hundreds  <= 4'd0;
      tens      <= 4'd0;
      ones      <= 4'd0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        overflow <= (bcd[19:16] != 4'd0);
`ifdef BCD_SATURATE_EN
        if (bcd[19:16] != 4'd0) begin
          thousands <= 4'd9;
          hundreds  <= 4'd9;
          tens      <= 4'd9;
          ones      <= 4'd9;
        end else begin
          thousands <= bcd[15:12];
          hundreds  <= bcd[11:8];
          tens      <= bcd[7:4];
          ones      <= bcd[3:0];
        end
`else
        thousands <= bcd[15:12];
        hundreds  <= bcd[11:8];
        tens      <= bcd[7:4];
        ones      <= bcd[3:0];
`endif
      end
    end
  end

endmodule
